mbox_mport: RTL

- Parametrised multi-port successor to the single-port MBOX memory front-end.
- Arbitrates NPORTS requesters, e.g. port 0 = EBOX and port 1 = channel/DMA, onto one single-port backing store of DEPTH words.
- Adds a programmable access latency, read-pause-write (PSE) locking, and nonexistent-memory (NXM) detection.
- Sits between EBOX/channel logic and the backing RAM; cache behaviour is out of scope.

---
 rtl/mbox_pkg.sv | 26 ++
 rtl/mbox_ram.sv | 24 ++
 rtl/mbox_mport.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mbox_pkg.sv
// Shared types and sizing constants for the multi-port MBOX memory front-end.
package mbox_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic pse;
  } op_t;

  localparam int MAX_PORTS = 8;
  localparam int MAX_LAT   = 15;
  localparam int PORT_W    = $clog2(MAX_PORTS);
  localparam int CNT_W     = $clog2(MAX_LAT + 1);

  // Read wins over write, and pause only means something on a read.
  function automatic op_t decode_op(input logic rd, input logic wr, input logic pse);
    op_t op;
    op.rd  = rd;
    op.wr  = wr & ~rd;
    op.pse = pse & rd;
    return op;
  endfunction

endpackage

// File: rtl/mbox_ram.sv
// Synchronous single-port backing store; stands in for the vendor RAM macro.
module mbox_ram #(
  parameter int DEPTH = 4096,
  parameter int DW    = 36,
  parameter int AB    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AB-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/mbox_mport.sv
// Multi-port MBOX front-end: round-robin arbitration onto one RAM with
// programmable latency, read-pause-write locking and NXM detection.
module mbox_mport
  import mbox_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int AW      = 23,
  parameter int DW      = 36,
  parameter int DEPTH   = 4096,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    read,
  input  logic [NPORTS-1:0]    write,
  input  logic [NPORTS-1:0]    pse,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] wdata,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        rdata,
  output logic [NPORTS-1:0]    nxm,
  output logic                 busy,
  output logic                 locked
);

  localparam int AB = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [PORT_W-1:0] rr_ptr, cur_port, owner, grant_idx;
  logic              grant_valid;
  logic [NPORTS-1:0] eligible;
  op_t               cur_op;
  logic [AB-1:0]     cur_addr;
  logic [DW-1:0]     cur_wdata, rdata_q, ram_dout, rd_word;
  logic              cur_nxm, ram_en, ram_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic              sel_rd, sel_wr, sel_pse;
  logic [NPORTS-1:0] cur_onehot;

  assign eligible = locked ? (req & (NPORTS'(1) << owner)) : req;

  // Search above the last winner first, then wrap to the bottom.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    for (int p = 0; p < NPORTS; p++) begin
      if (!grant_valid && eligible[p] && (p > int'(rr_ptr))) begin
        grant_valid = 1'b1;
        grant_idx   = PORT_W'(p);
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (!grant_valid && eligible[p]) begin
        grant_valid = 1'b1;
        grant_idx   = PORT_W'(p);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_pse   = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (PORT_W'(p) == grant_idx) begin
        sel_addr  = addr[p*AW +: AW];
        sel_wdata = wdata[p*DW +: DW];
        sel_rd    = read[p];
        sel_wr    = write[p];
        sel_pse   = pse[p];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // RAM read is launched in the final ACCESS cycle; writes commit at the end of DONE.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    case (state)
      IDLE:   if (grant_valid) state_nxt = ACCESS;
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          ram_en    = cur_op.rd && !cur_nxm;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ram_en    = cur_op.wr && !cur_nxm;
        ram_we    = cur_op.wr && !cur_nxm;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt       <= '0;
      rr_ptr    <= PORT_W'(NPORTS - 1);
      cur_port  <= '0;
      cur_op    <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_nxm   <= 1'b0;
      locked    <= 1'b0;
      owner     <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_port  <= grant_idx;
            cur_op    <= decode_op(sel_rd, sel_wr, sel_pse);
            cur_addr  <= sel_addr[AB-1:0];
            cur_wdata <= sel_wdata;
            cur_nxm   <= {1'b0, sel_addr} >= DEPTH_W;
            rr_ptr    <= grant_idx;
            cnt       <= CNT_W'(MEM_LAT - 1);
          end
        end
        ACCESS: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        DONE: begin
          if (cur_op.rd) rdata_q <= rd_word;
          if (cur_op.pse) begin
            locked <= 1'b1;
            owner  <= cur_port;
          end else if (locked && (cur_port == owner)) begin
            locked <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  mbox_ram #(.DEPTH(DEPTH), .DW(DW), .AB(AB)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (cur_addr),
    .din  (cur_wdata),
    .dout (ram_dout)
  );

  assign rd_word    = cur_nxm ? '0 : ram_dout;
  assign cur_onehot = NPORTS'(1) << cur_port;
  assign ack        = (state == DONE) ? cur_onehot : '0;
  assign nxm        = (state == DONE && cur_nxm) ? cur_onehot : '0;
  assign rdata      = (state == DONE && cur_op.rd) ? rd_word : rdata_q;
  assign busy       = (state != IDLE);

endmodule
